// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory, redirect and decode handshake bundle of the fetch stage.
interface instr_fetch_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] pc;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, 1-cycle imem reads, 2-entry instruction queue to decode with redirect flush.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    logic [XLEN-1:0] pc_q, flight_pc, addr;
    logic [XLEN-1:0] q_inst [2];
    logic [XLEN-1:0] q_pc [2];
    logic            flight, head, tail, valid, pop, push, req;
    logic [1:0]      count;
    logic [2:0]      occ;
    always_comb begin
        valid = !rst && (count != 2'd0);
        pop   = valid && bus.inst_ready;
        push  = flight && !bus.redirect_valid;
        // occupancy after this edge if no request is issued now
        occ   = {1'b0, count} + {2'b0, flight} - {2'b0, pop};
        req   = !rst && (bus.redirect_valid || occ < 3'd2);
        addr  = bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : pc_q;
    end
    assign bus.imem_req   = req;
    assign bus.imem_addr  = addr;
    assign bus.inst_valid = valid;
    assign bus.inst       = q_inst[head];
    assign bus.inst_pc    = q_pc[head];
    assign bus.pc         = pc_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            flight <= 1'b0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            flight    <= req;
            flight_pc <= addr;
            if (req) pc_q <= addr + XLEN'(4);
            if (bus.redirect_valid) begin
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push) begin
                    q_inst[tail] <= bus.imem_rdata;
                    q_pc[tail]   <= flight_pc;
                    tail         <= ~tail;
                end
                if (pop) head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of decode inside the cpu core. It owns the fetch PC and issues word reads to the synchronous instruction memory. Fetched words and their PCs are buffered in a 2-entry queue and presented to decode over a valid/ready handshake. Decode or execute can redirect the fetch PC on a branch or jump. The fetch PC is exported so the system testbench monitor can print it.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
XLEN, 32, width of the PC and the instruction word.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-high.
imem_req  out  1  read strobe to instruction memory.
imem_addr  out  XLEN  byte address of the read; bits [1:0] are always 0.
imem_rdata  in  XLEN  read data; valid in the cycle after imem_req=1 (fixed 1-cycle latency).
redirect_valid  in  1  branch/jump taken; load a new PC this cycle.
redirect_pc  in  XLEN  target PC; bits [1:0] ignored and forced to 0.
inst_valid  out  1  queue head holds an instruction.
inst_ready  in  1  decode accepts the head this cycle.
inst  out  XLEN  instruction word at the queue head.
inst_pc  out  XLEN  PC of inst.
pc  out  XLEN  current fetch PC (next address to request).

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC; queue emptied; in-flight flag cleared. During any cycle with rst=1: imem_req=0 and inst_valid=0. inst and inst_pc are don't-care while inst_valid=0.
- In-flight flag: registered copy of imem_req. When set, the response in imem_rdata is written to the queue tail together with its request PC at the next edge, unless it is dropped (see redirect).
- Queue: 2 entries, circular, with head/tail pointers and a 2-bit count.
  - inst, inst_pc and inst_valid come from registered queue storage (no bypass from imem_rdata).
  - A pop happens when inst_valid & inst_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo 2.
- Issue rule: imem_req=1 when rst=0 and (count + inflight − pop) < 2. This guarantees the queue never overflows and gives 1 instruction/cycle sustained when inst_ready is held high.
- On issue without redirect: imem_addr=pc, and pc ← pc+4 (modulo 2^XLEN; 0xFFFF_FFFC wraps to 0).
- Latency: request in cycle T → data in cycle T+1 → inst_valid=1 in cycle T+2. After rst falls, the first inst_valid is in the 3rd cycle.
- Redirect cycle (redirect_valid=1, rst=0):
  - A pop handshake in this cycle still completes.
  - The queue is cleared at the edge.
  - The response arriving this cycle is dropped.
  - imem_req=1 and imem_addr={redirect_pc[XLEN-1:2],2'b00} combinationally in the same cycle; pc ← that address + 4.
  - The redirect target appears at inst_valid two cycles later: 2-cycle bubble.
- Redirect on back-to-back cycles: the last one wins; every earlier target's response is dropped.
- rst and redirect_valid together: rst wins.
- Stall (inst_ready=0): the head holds stable; inst, inst_pc and inst_valid must not change until popped or flushed.

Test Plan:
- Reset release, inst_ready=1, memory word[i]=i: inst_pc 0,4,8,… one per cycle starting in the 3rd cycle after rst falls; imem_addr never skips or repeats.
- Hold inst_ready=0 from cycle 5 for 6 cycles: count reaches 2, then imem_req=0. The head stays constant with inst_pc=0x8. Release → 0x8, 0xC, 0x10 with no gap or loss.
- redirect_valid=1, redirect_pc=0x103 while fetching sequentially: imem_addr=0x100 the same cycle. The next inst_valid has inst_pc=0x100, after a 2-cycle bubble. No pre-redirect PC appears after it.
- Redirect in two consecutive cycles to 0x40 then 0x80: only 0x80, 0x84, … are delivered.
- rst=1 asserted mid-stream with the queue full: the next cycle shows inst_valid=0, imem_req=0 and pc=RESET_PC. The stale response is never delivered.
- Redirect from pc=0xFFFF_FFFC: the fetch sequence continues 0xFFFF_FFFC then 0x0000_0000.
